// File: rtl/debounce_ctrl.sv
// Push-button debounce controller: 2-FF synchronizer, prescaled sample strobe,
// SAMPLES-deep history and press/release FSM. Long-press detection: DEBOUNCE_LONG_PRESS_EN.
module debounce_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLES  = 4,
    parameter int LONG_CNT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic enable,
    output logic sample_tick,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (SAMPLES < 2) begin : g_bad_samples
        $error("SAMPLES must be at least 2");
    end
    if (LONG_CNT < 1) begin : g_bad_long
        $error("LONG_CNT must be at least 1");
    end

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_e;

    logic               sync1_q, sync2_q, btn_s;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               tick_q, tick_d;
    logic [SAMPLES-1:0] hist_q, hist_d;
    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               all_hi, all_lo;

    assign btn_s  = sync2_q;
    assign all_hi = &hist_q;
    assign all_lo = ~|hist_q;

    // Synchronizer always runs; everything else freezes while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            hist_q    <= '0;
            state_q   <= ST_RELEASED;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Prescaler, history shift and press/release next-state logic.
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = tick_q;
        hist_d    = hist_q;
        state_d   = state_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (enable) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                tick_d    = 1'b0;
            end
            if (tick_q) begin
                hist_d = {btn_s, hist_q[SAMPLES-1:1]};
            end else begin
                hist_d = hist_q;
            end
            // A mixed history keeps the state, so one glitch sample blocks a transition.
            case (state_q)
                ST_RELEASED: begin
                    if (all_hi) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASED;
                    end
                end
                ST_PRESSED: begin
                    if (all_lo) begin
                        state_d   = ST_RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    level_d = 1'b0;
                end
            endcase
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CNT + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CNT);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_q, long_d;

    // Long-press counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    // Counts ticks spent in PRESSED, saturating so each press yields one long_pulse.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (enable) begin
            if ((state_q == ST_PRESSED) && (state_d == ST_PRESSED)) begin
                if (tick_q && (long_cnt_q < LONG_MAX)) begin
                    long_cnt_d = long_cnt_q + 1'b1;
                    long_d     = (long_cnt_q == (LONG_MAX - 1'b1));
                end else begin
                    long_cnt_d = long_cnt_q;
                end
            end else begin
                long_cnt_d = '0;
            end
        end else begin
            long_cnt_d = long_cnt_q;
        end
    end

    assign long_pulse = long_q & enable;
`else
    assign long_pulse = 1'b0;
`endif

    // Gating with enable drops a strobe that is in flight when enable falls.
    assign sample_tick   = tick_q & enable;
    assign btn_level     = level_q;
    assign press_pulse   = press_q & enable;
    assign release_pulse = release_q & enable;
endmodule

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl: a spec-level sample/FSM model pushes
// expected pulse events into a scoreboard queue that a negedge monitor consumes.
module tb_debounce_ctrl;
    localparam int SAMPLES  = 4;
    localparam int LONG_CNT = 8;

    logic clk;
    logic reset, btn_in, enable;
    logic sample_tick, btn_level, press_pulse, release_pulse, long_pulse;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulse_cnt [3];
    int exp_kind [$];
    int exp_cyc [$];

    logic               s1_m = 1'b0, s2_m = 1'b0;
    logic [SAMPLES-1:0] hist_m = '0;
    logic               state_m = 1'b0;
    int                 lcnt_m = 0;

    debounce_ctrl #(.CLK_DIV(4), .SAMPLES(SAMPLES), .LONG_CNT(LONG_CNT)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
        .sample_tick(sample_tick), .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-flop synchronizer as seen by the sampler.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                s1_m = 1'b0;
                s2_m = 1'b0;
            end else begin
                s2_m = s1_m;
                s1_m = btn_in;
            end
        end
    end

    // Scoreboard: match pulses against queued events, then advance the model on each tick.
    initial begin
        logic pulse;
        pulse_cnt = '{0, 0, 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                hist_m = '0; state_m = 1'b0; lcnt_m = 0;
                exp_kind.delete(); exp_cyc.delete();
            end else begin
                while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_event: kind %0d required at cycle %0d, not seen by cycle %0d",
                             exp_kind[0], exp_cyc[0], cyc);
                    void'(exp_kind.pop_front()); void'(exp_cyc.pop_front());
                end
                for (int k = 0; k < 3; k++) begin
                    pulse = (k == 0) ? press_pulse : ((k == 1) ? release_pulse : long_pulse);
                    if (pulse !== 1'b0) begin
                        checks++;
                        pulse_cnt[k]++;
                        if (exp_kind.size() == 0 || exp_kind[0] != k || exp_cyc[0] != cyc) begin
                            errors++;
                            $display("FAIL pulse_event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                     k, cyc, (exp_kind.size() > 0) ? exp_kind[0] : -1,
                                     (exp_cyc.size() > 0) ? exp_cyc[0] : -1);
                        end else begin
                            void'(exp_kind.pop_front()); void'(exp_cyc.pop_front());
                        end
                    end
                end
                if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
                    checks++;
                    if (btn_level !== press_pulse) begin
                        errors++;
                        $display("FAIL level_at_pulse: btn_level=%b required %b", btn_level, press_pulse);
                    end
                end
                if (sample_tick === 1'b1) begin
                    hist_m = {s2_m, hist_m[SAMPLES-1:1]};
`ifdef DEBOUNCE_LONG_PRESS_EN
                    if (state_m && lcnt_m < LONG_CNT) begin
                        lcnt_m++;
                        if (lcnt_m == LONG_CNT) begin
                            exp_kind.push_back(2); exp_cyc.push_back(cyc + 1);
                        end
                    end
`endif
                    if (!state_m && (&hist_m)) begin
                        exp_kind.push_back(0); exp_cyc.push_back(cyc + 2);
                        state_m = 1'b1; lcnt_m = 0;
                    end else if (state_m && !(|hist_m)) begin
                        exp_kind.push_back(1); exp_cyc.push_back(cyc + 2);
                        state_m = 1'b0; lcnt_m = 0;
                    end
                end
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (sample_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sample_tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: sample_tick=%b after %0d cycles, required 1", sample_tick, n);
        end
        #1;
    endtask

    task automatic apply(input logic val, input int nticks);
        btn_in = val;
        repeat (nticks) wait_tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_in = 1'b1; enable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({sample_tick, btn_level, press_pulse, release_pulse, long_pulse} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs: got %b required 00000",
                         {sample_tick, btn_level, press_pulse, release_pulse, long_pulse});
            end
        end
        #1 reset = 1'b0;
        // Ticks fall every 4th cycle; the 4th 1-sample lands at k=16, press follows at k=18.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if ({sample_tick, press_pulse} !== {1'(k % 4 == 0), 1'(k == 18)}) begin
                errors++;
                $display("FAIL first_ticks k=%0d: tick/press=%b%b required %b%b", k,
                         sample_tick, press_pulse, 1'(k % 4 == 0), 1'(k == 18));
            end
        end
        #1;
        checks++;
        if (btn_level !== 1'b1) begin
            errors++; $display("FAIL level_after_press: got %b required 1", btn_level);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int p0, r0;
        r0 = pulse_cnt[1];
        apply(1'b0, 6);
        checks++;
        if (pulse_cnt[1] !== r0 + 1 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_setup_release: releases=%0d level=%b required %0d and 0",
                     pulse_cnt[1] - r0, btn_level, 1);
        end
        p0 = pulse_cnt[0];
        pat = 6'b101101;
        for (int i = 5; i >= 0; i--) apply(pat[i], 1);
        checks++;
        if (pulse_cnt[0] !== p0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_press: presses=%0d level=%b required 0 and 0", pulse_cnt[0] - p0, btn_level);
        end
        apply(1'b1, 4);
        checks++;
        if (pulse_cnt[0] !== p0 + 1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL bounce_press: presses=%0d level=%b required 1 and 1", pulse_cnt[0] - p0, btn_level);
        end
    endtask

    task automatic test_release();
        int r0;
        r0 = pulse_cnt[1];
        apply(1'b0, 3);
        apply(1'b1, 1);
        checks++;
        if (pulse_cnt[1] !== r0 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL release_glitch: releases=%0d level=%b required 0 and 1", pulse_cnt[1] - r0, btn_level);
        end
        apply(1'b0, 5);
        checks++;
        if (pulse_cnt[1] !== r0 + 1 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL release_qualified: releases=%0d level=%b required 1 and 0", pulse_cnt[1] - r0, btn_level);
        end
    endtask

    task automatic test_enable_freeze();
        int p0, n;
        p0 = pulse_cnt[0];
        apply(1'b1, 2);
        @(negedge clk);
        #1 enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({sample_tick, press_pulse, release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL frozen_outputs k=%0d: got %b required 000", k, {sample_tick, press_pulse, release_pulse});
            end
        end
        #1 enable = 1'b1;
        // One prescaler cycle was used before the freeze, so three remain to the next tick.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_tick !== 1'b1 && n < 10);
        #1;
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL resume_tick_delay: got %0d cycles required 3", n);
        end
        checks++;
        if (pulse_cnt[0] !== p0) begin
            errors++; $display("FAIL resume_early_press: presses=%0d required 0", pulse_cnt[0] - p0);
        end
        apply(1'b1, 2);
        checks++;
        if (pulse_cnt[0] !== p0 + 1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL resume_press: presses=%0d level=%b required 1 and 1", pulse_cnt[0] - p0, btn_level);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0, r0;
        p0 = pulse_cnt[0];
        r0 = pulse_cnt[1];
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_outputs: got %b required 000", {btn_level, press_pulse, release_pulse});
            end
        end
        #1 reset = 1'b0;
        apply(1'b1, 5);
        checks++;
        if (pulse_cnt[0] !== p0 + 1 || pulse_cnt[1] !== r0 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL midreset_repress: presses=%0d releases=%0d level=%b required 1, 0, 1",
                     pulse_cnt[0] - p0, pulse_cnt[1] - r0, btn_level);
        end
    endtask

    task automatic test_long_press();
        int l0;
        l0 = pulse_cnt[2];
        apply(1'b1, 20);
        checks++;
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (pulse_cnt[2] !== l0 + 1) begin
            errors++; $display("FAIL long_pulse_count: got %0d required 1", pulse_cnt[2] - l0);
        end
`else
        if (pulse_cnt[2] !== 0) begin
            errors++; $display("FAIL long_pulse_disabled: got %0d pulses required 0", pulse_cnt[2]);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; btn_in = 1'b0; enable = 1'b0;
        test_reset();
        test_bounce();
        test_release();
        test_enable_freeze();
        test_reset_mid_press();
        test_long_press();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (exp_kind.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d events left, required 0", exp_kind.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
